kb_axil_arbiter: RTL and testbench

- Shares one AXI4-Lite master port between NUM_REQ on-chip requesters, e.g. the keyboard scan logic and the game-state logic, both reaching the kb_slave register bank.
- Accepts simple single-word read/write commands and serialises them with round-robin arbitration.
- Allows exactly one outstanding AXI transaction and returns the response to the requester that issued it.

---
 rtl/kb_axil_pkg.sv | 29 ++
 rtl/kb_rr_arbiter.sv | 43 ++++
 rtl/kb_axil_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_kb_axil_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kb_axil_pkg.sv
// kb_axil_pkg
//   Shared types and constants for the kb_axil_arbiter slice: AXI response
//   codes, the arbiter FSM state encoding and the requester-index width.
package kb_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Default requester count of the slice; modules derive their own width
    // from their NUM_REQ parameter through id_width().
    localparam int unsigned NUM_REQ_DEF = 2;

    // Width of an encoded requester index, never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned ID_W = id_width(NUM_REQ_DEF);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_RESP
    } state_t;

endpackage

// File: rtl/kb_rr_arbiter.sv
// kb_rr_arbiter
//   Combinational round-robin grant: picks the first set request bit at or
//   above the priority pointer, wrapping around.
//   req_i   : per-requester request vector
//   ptr_i   : index with highest priority this round
//   grant_o : one-hot grant (all zero when no request)
//   idx_o   : encoded index of the granted requester
module kb_rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDW     = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDW-1:0]     idx_o
);

    logic              found;
    int unsigned       ksum;
    logic [IDW-1:0]    k;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        ksum    = 0;
        k       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            // (ptr + i) mod NUM_REQ without a divider: i < NUM_REQ, ptr < NUM_REQ
            ksum = 32'(ptr_i) + i;
            if (ksum >= NUM_REQ) begin
                ksum = ksum - NUM_REQ;
            end
            k = IDW'(ksum);
            if (!found && req_i[k]) begin
                found      = 1'b1;
                grant_o[k] = 1'b1;
                idx_o      = k;
            end
        end
    end

endmodule

// File: rtl/kb_axil_arbiter.sv
// kb_axil_arbiter
//   Shares one AXI4-Lite master port between NUM_REQ requesters. Commands are
//   single-word reads/writes, granted round-robin, one outstanding AXI
//   transaction at a time, response routed back with the owner's index.
//   ACLK/ARESETN : clock, asynchronous active-low reset
//   req_*        : packed per-requester command interface (valid/ready/we/
//                  addr/wdata/wstrb); req_ready is a one-cycle accept pulse
//   rsp_*        : one-cycle response pulse with owner id, read data, resp
//   m_axi_*      : AXI4-Lite master port
module kb_axil_arbiter
    import kb_axil_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wstrb,
    output logic                           rsp_valid,
    output logic [id_width(NUM_REQ)-1:0]   rsp_id,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic [1:0]                     rsp_resp,
    output logic [ADDR_WIDTH-1:0]          m_axi_awaddr,
    output logic [2:0]                     m_axi_awprot,
    output logic                           m_axi_awvalid,
    input  logic                           m_axi_awready,
    output logic [DATA_WIDTH-1:0]          m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]        m_axi_wstrb,
    output logic                           m_axi_wvalid,
    input  logic                           m_axi_wready,
    input  logic [1:0]                     m_axi_bresp,
    input  logic                           m_axi_bvalid,
    output logic                           m_axi_bready,
    output logic [ADDR_WIDTH-1:0]          m_axi_araddr,
    output logic [2:0]                     m_axi_arprot,
    output logic                           m_axi_arvalid,
    input  logic                           m_axi_arready,
    input  logic [DATA_WIDTH-1:0]          m_axi_rdata,
    input  logic [1:0]                     m_axi_rresp,
    input  logic                           m_axi_rvalid,
    output logic                           m_axi_rready
);

    localparam int unsigned IDW    = id_width(NUM_REQ);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    state_t                  state_q, state_d;
    logic [IDW-1:0]          ptr_q, ptr_d;
    logic [IDW-1:0]          id_q, id_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;

    logic [NUM_REQ-1:0]      grant;
    logic [IDW-1:0]          grant_idx;
    int unsigned             gsel;

    kb_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (grant_idx)
    );

    assign gsel = 32'(grant_idx);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        id_d          = id_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        rdata_d       = rdata_q;
        resp_d        = resp_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        req_ready     = '0;
        rsp_valid     = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                // Grant is combinational; held off while reset is asserted so
                // req_ready reads 0 during reset.
                if (ARESETN && (|req_valid)) begin
                    req_ready = grant;
                    id_d      = grant_idx;
                    addr_d    = {req_addr[gsel*ADDR_WIDTH+2 +: ADDR_WIDTH-2], 2'b00};
                    wdata_d   = req_wdata[gsel*DATA_WIDTH +: DATA_WIDTH];
                    wstrb_d   = req_wstrb[gsel*STRB_W +: STRB_W];
                    ptr_d     = (gsel == NUM_REQ - 1) ? '0 : IDW'(gsel + 1);
                    state_d   = req_we[grant_idx] ? ST_WR : ST_RD_ADDR;
                end
            end
            ST_WR: begin
                // AW and W complete independently, possibly in the same cycle.
                m_axi_awvalid = !aw_done_q;
                m_axi_wvalid  = !w_done_q;
                if (m_axi_awvalid && m_axi_awready) aw_done_d = 1'b1;
                if (m_axi_wvalid && m_axi_wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    resp_d  = m_axi_bresp;
                    rdata_d = '0;
                    state_d = ST_RESP;
                end
            end
            ST_RD_ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) begin
                    rdata_d = m_axi_rdata;
                    resp_d  = m_axi_rresp;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rsp_id       = id_q;
    assign rsp_rdata    = rdata_q;
    assign rsp_resp     = resp_q;
    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_wdata  = wdata_q;
    assign m_axi_wstrb  = wstrb_q;
    assign m_axi_awprot = '0;
    assign m_axi_arprot = '0;

endmodule

// File: tb/tb_kb_axil_arbiter.sv
// tb_kb_axil_arbiter
//   Scoreboard bench for kb_axil_arbiter with a small AXI4-Lite slave model
//   (programmable awready delay, rvalid delay and SLVERR injection).
module tb_kb_axil_arbiter;

    logic        ACLK;
    logic        ARESETN;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [7:0]  req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic        rsp_valid;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [3:0]  m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [3:0]  m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    kb_axil_arbiter #(
        .NUM_REQ    (2),
        .ADDR_WIDTH (4),
        .DATA_WIDTH (32)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_wstrb     (req_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_id        (rsp_id),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awprot  (m_axi_awprot),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // ---------------- cycle counter and channel monitors ----------------
    int unsigned cyc = 0;
    int unsigned aw_cyc = 0, w_cyc = 0, b_hs = 0;
    logic [3:0]  last_awaddr = '0;

    always @(posedge ACLK) begin
        cyc <= cyc + 1;
        if (m_axi_awvalid) aw_cyc <= aw_cyc + 1;
        if (m_axi_wvalid)  w_cyc  <= w_cyc + 1;
        if (m_axi_bvalid && m_axi_bready) b_hs <= b_hs + 1;
        if (m_axi_awvalid && m_axi_awready) last_awaddr <= m_axi_awaddr;
    end

    // ---------------- AXI4-Lite slave model ----------------
    int unsigned aw_delay = 0;
    int unsigned r_delay  = 0;
    bit          err_en   = 1'b0;
    logic [1:0]  err_word = 2'd0;

    logic [31:0] smem [4];
    logic        aw_got, w_got, r_pend;
    logic [3:0]  aw_a, ar_a, w_s, a_use, s_use;
    logic [31:0] w_d, d_use;
    logic        aw_hs, w_hs, aw_now, w_now;
    int unsigned aw_cnt, r_cnt;

    assign m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_delay);
    assign m_axi_wready  = 1'b1;
    assign m_axi_arready = 1'b1;
    assign aw_hs  = m_axi_awvalid && m_axi_awready;
    assign w_hs   = m_axi_wvalid && m_axi_wready;
    assign aw_now = aw_got || aw_hs;
    assign w_now  = w_got || w_hs;
    assign a_use  = aw_got ? aw_a : m_axi_awaddr;
    assign d_use  = w_got ? w_d : m_axi_wdata;
    assign s_use  = w_got ? w_s : m_axi_wstrb;

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
            aw_cnt <= 0; r_cnt <= 0;
            aw_a <= '0; ar_a <= '0; w_d <= '0; w_s <= '0;
            m_axi_bvalid <= 1'b0; m_axi_bresp <= 2'b00;
            m_axi_rvalid <= 1'b0; m_axi_rresp <= 2'b00; m_axi_rdata <= '0;
        end else begin
            if (m_axi_awvalid && !m_axi_awready) aw_cnt <= aw_cnt + 1;
            if (aw_hs) begin aw_cnt <= 0; aw_got <= 1'b1; aw_a <= m_axi_awaddr; end
            if (w_hs) begin w_got <= 1'b1; w_d <= m_axi_wdata; w_s <= m_axi_wstrb; end
            if (aw_now && w_now && !m_axi_bvalid) begin
                for (int b = 0; b < 4; b++)
                    if (s_use[b]) smem[a_use[3:2]][8*b +: 8] <= d_use[8*b +: 8];
                m_axi_bvalid <= 1'b1;
                m_axi_bresp  <= 2'b00;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
            if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;

            if (m_axi_arvalid && m_axi_arready) begin
                ar_a <= m_axi_araddr;
                if (r_delay == 0) begin
                    m_axi_rvalid <= 1'b1;
                    m_axi_rdata  <= smem[m_axi_araddr[3:2]];
                    m_axi_rresp  <= (err_en && m_axi_araddr[3:2] == err_word) ? 2'b10 : 2'b00;
                end else begin
                    r_pend <= 1'b1;
                    r_cnt  <= 1;
                end
            end else if (r_pend) begin
                if (r_cnt >= r_delay) begin
                    m_axi_rvalid <= 1'b1;
                    m_axi_rdata  <= smem[ar_a[3:2]];
                    m_axi_rresp  <= (err_en && ar_a[3:2] == err_word) ? 2'b10 : 2'b00;
                    r_pend <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 1;
                end
            end
            if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          id;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int unsigned acc;
        bit          chk_lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [4];
    bit          gseq[$];

    always @(negedge ACLK) begin
        if (ARESETN && rsp_valid) begin
            if (sb.size() == 0) begin
                check_eq("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                check_eq("rsp_id",    32'(rsp_id),    32'(sb[0].id));
                check_eq("rsp_rdata", rsp_rdata,      sb[0].rdata);
                check_eq("rsp_resp",  32'(rsp_resp),  32'(sb[0].resp));
                if (sb[0].chk_lat) check_eq("rsp_latency", cyc - sb[0].acc, 32'd3);
                void'(sb.pop_front());
            end
        end
    end

    task automatic issue(input bit k, input logic we, input logic [3:0] addr,
                         input logic [31:0] data, input bit chk_lat);
        int unsigned waited;
        exp_t e;
        waited = 0;
        @(negedge ACLK);
        req_valid[k]          = 1'b1;
        req_we[k]             = we;
        req_addr[k*4 +: 4]    = addr;
        req_wdata[k*32 +: 32] = data;
        req_wstrb[k*4 +: 4]   = 4'hF;
        #1;
        while (!req_ready[k] && waited < 100) begin
            @(negedge ACLK); #1;
            waited++;
        end
        if (!req_ready[k]) begin
            check_eq("accept_timeout", 32'd0, 32'd1);
            req_valid[k] = 1'b0;
            return;
        end
        e.id      = k;
        e.acc     = cyc;
        e.chk_lat = chk_lat;
        if (we) begin
            ref_mem[addr[3:2]] = data;
            e.rdata = 32'd0;
            e.resp  = 2'b00;
        end else begin
            e.rdata = ref_mem[addr[3:2]];
            e.resp  = (err_en && addr[3:2] == err_word) ? 2'b10 : 2'b00;
        end
        sb.push_back(e);
        gseq.push_back(k);
        @(posedge ACLK); #1;
        req_valid[k] = 1'b0;
    endtask

    task automatic drain();
        int unsigned w;
        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(negedge ACLK);
            w++;
        end
        check_eq("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge ACLK);
        ARESETN = 1'b0;
        sb.delete();
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
    endtask

    int unsigned aw0, w0, b0, waitc;

    initial begin
        ARESETN   = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        repeat (3) @(negedge ACLK);
        #1;
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_axi_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 32'd0);
        check_eq("rst_axi_readys", 32'({m_axi_bready, m_axi_rready}), 32'd0);
        check_eq("rst_rsp_data", rsp_rdata, 32'd0);
        check_eq("rst_rsp_idresp", 32'({rsp_id, rsp_resp}), 32'd0);
        @(negedge ACLK);
        ARESETN = 1'b1;

        // Single requester: write four words then read them back.
        for (int i = 0; i < 4; i++) issue(1'b0, 1'b1, 4'(i*4), 32'(i+1), 1'b1);
        for (int i = 0; i < 4; i++) issue(1'b0, 1'b0, 4'(i*4), 32'd0, 1'b1);
        drain();
        check_eq("wr_data_0xC", smem[3], 32'd4);

        // Both requesters contend: strict alternation from pointer 0.
        do_reset();
        gseq.delete();
        fork
            begin
                for (int i = 0; i < 3; i++) issue(1'b0, 1'b1, 4'h0, 32'h100 + 32'(i), 1'b1);
            end
            begin
                for (int i = 0; i < 3; i++) issue(1'b1, 1'b0, 4'h4, 32'd0, 1'b1);
            end
        join
        drain();
        check_eq("grant_count", 32'(gseq.size()), 32'd6);
        for (int i = 0; i < 6 && i < gseq.size(); i++)
            check_eq("grant_order", 32'(gseq[i]), 32'(i % 2));

        // Slow awready, immediate wready.
        aw0 = aw_cyc; w0 = w_cyc; b0 = b_hs;
        aw_delay = 2;
        issue(1'b0, 1'b1, 4'h8, 32'h55, 1'b0);
        drain();
        aw_delay = 0;
        check_eq("slow_aw_awvalid_cycles", aw_cyc - aw0, 32'd3);
        check_eq("slow_aw_wvalid_cycles", w_cyc - w0, 32'd1);
        check_eq("slow_aw_b_handshakes", b_hs - b0, 32'd1);
        check_eq("slow_aw_mem", smem[2], 32'h55);

        // Unaligned address from requester 1 is word-aligned on the bus.
        issue(1'b1, 1'b1, 4'h7, 32'hAB, 1'b1);
        drain();
        check_eq("awaddr_align", 32'(last_awaddr), 32'h4);

        // SLVERR on read of 0x4 passes through; next command still served.
        err_en = 1'b1; err_word = 2'd1;
        issue(1'b0, 1'b0, 4'h4, 32'd0, 1'b1);
        drain();
        err_en = 1'b0;
        issue(1'b1, 1'b0, 4'h0, 32'd0, 1'b1);
        drain();

        // Reset while waiting in RD_DATA.
        r_delay = 20;
        issue(1'b0, 1'b0, 4'h0, 32'd0, 1'b0);
        waitc = 0;
        while (!m_axi_rready && waitc < 20) begin
            @(negedge ACLK); #1;
            waitc++;
        end
        check_eq("rd_data_reached", 32'(m_axi_rready), 32'd1);
        @(negedge ACLK);
        ARESETN = 1'b0;
        sb.delete();
        #1;
        check_eq("rst_mid_arvalid", 32'(m_axi_arvalid), 32'd0);
        check_eq("rst_mid_rready", 32'(m_axi_rready), 32'd0);
        check_eq("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_mid_ptr", 32'(dut.ptr_q), 32'd0);
        r_delay = 0;
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        issue(1'b1, 1'b0, 4'h8, 32'd0, 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
